seven_seg_display_driver: RTL

- Downstream consumer of the rotating active-low anode select produced by the four-digit scanner on div_clock.
- Runs on the fast system clock and synchronizes the scanner's anode pattern into that domain.
- Holds a double-buffered 16-bit hex value, so a new value is applied only at a frame boundary and the display never tears.
- Drives anodes, segments and decimal point to the board, with anti-ghost blanking on every digit change and optional leading-zero blanking.

---
 rtl/seven_seg_display_driver.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/seven_seg_display_driver.sv
// rtl/seven_seg_display_driver.sv - four-digit seven-segment driver fed by an asynchronous anode scanner
// Double-buffered hex value, anti-ghost blanking, leading-zero blanking, sticky illegal-pattern flag.
module seven_seg_display_driver #(
  parameter int GHOST_CYCLES = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  anode_in,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  dp_in,
  input  logic        blank_zeros,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done,
  output logic        pattern_err
);

  localparam int          SW         = SYNC_STAGES * 4;
  localparam logic [7:0]  GHOST_LOAD = 8'(GHOST_CYCLES);
  localparam logic [6:0]  SEG_OFF    = 7'h7F;

  logic [SW-1:0] sync_q, sync_d;
  logic [3:0]    anode_prev_q, anode_prev_d;
  logic [19:0]   shadow_q, shadow_d;
  logic [19:0]   active_q, active_d;
  logic          pending_q, pending_d;
  logic [7:0]    ghost_q, ghost_d;
  logic [3:0]    anode_q, anode_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_done_q, frame_done_d;
  logic          pattern_err_q, pattern_err_d;

  logic [3:0] anode_sync;
  logic       change, boundary, legal, idle;
  logic [1:0] sel;
  logic [3:0] digit;
  logic       d3z, d2z, d1z, lz_blank;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign anode_sync = sync_q[SW-1 -: 4];

  always_comb begin
    sel   = 2'd0;
    legal = 1'b0;
    idle  = 1'b0;
    case (anode_sync)
      4'b1110: begin sel = 2'd0; legal = 1'b1; end
      4'b1101: begin sel = 2'd1; legal = 1'b1; end
      4'b1011: begin sel = 2'd2; legal = 1'b1; end
      4'b0111: begin sel = 2'd3; legal = 1'b1; end
      4'b1111: idle = 1'b1;
      default: ;
    endcase
  end

  assign change   = (anode_sync != anode_prev_q);
  assign boundary = (anode_sync == 4'b1110) && (anode_prev_q != 4'b1110);

  always_comb begin
    sync_d        = {sync_q[SW-5:0], anode_in};
    anode_prev_d  = anode_sync;
    frame_done_d  = boundary;
    pattern_err_d = pattern_err_q | ~(legal | idle);

    // A load coinciding with a boundary promotes the old shadow first, then refills it.
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (boundary && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (load) begin
      shadow_d  = {dp_in, value};
      pending_d = 1'b1;
    end

    if (change)
      ghost_d = GHOST_LOAD;
    else if (ghost_q != 8'd0)
      ghost_d = ghost_q - 8'd1;
    else
      ghost_d = ghost_q;
  end

  always_comb begin
    digit    = active_q[{sel, 2'b00} +: 4];
    d3z      = (active_q[15:12] == 4'h0);
    d2z      = (active_q[11:8] == 4'h0);
    d1z      = (active_q[7:4] == 4'h0);
    lz_blank = blank_zeros && (((sel == 2'd3) && d3z) ||
                               ((sel == 2'd2) && d3z && d2z) ||
                               ((sel == 2'd1) && d3z && d2z && d1z));

    anode_d = 4'b1111;
    seg_d   = SEG_OFF;
    dp_d    = 1'b1;
    if (legal && !change && (ghost_q == 8'd0)) begin
      anode_d = anode_sync;
      seg_d   = lz_blank ? SEG_OFF : hex7(digit);
      dp_d    = ~active_q[{3'b100, sel}];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q        <= '1;
      anode_prev_q  <= 4'b1111;
      shadow_q      <= '0;
      active_q      <= '0;
      pending_q     <= 1'b0;
      ghost_q       <= 8'd0;
      anode_q       <= 4'b1111;
      seg_q         <= SEG_OFF;
      dp_q          <= 1'b1;
      frame_done_q  <= 1'b0;
      pattern_err_q <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      anode_prev_q  <= anode_prev_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      pending_q     <= pending_d;
      ghost_q       <= ghost_d;
      anode_q       <= anode_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_done_q  <= frame_done_d;
      pattern_err_q <= pattern_err_d;
    end
  end

  assign anode       = anode_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_done  = frame_done_q;
  assign pattern_err = pattern_err_q;

endmodule
